host_cmd_master: RTL and testbench
==================================

# host_cmd_master

Synthesizable host-side initiator for the FT2232-style byte-FIFO register protocol served by `host_iface`. It plays the FT2232 role: it accepts one register command at a time from local logic, presents the 8-byte command frame to the core via the RX-FIFO handshake, and collects the 5-byte reply from the core via the TX-FIFO handshake. It is used for on-chip loopback/self-test of `host_iface` and as a bridge for an auxiliary command source. It shares the core's single clock domain.

## Interface
- `TIMEOUT_CYCLES`, 1024: idle cycles allowed between byte events before the transaction aborts.
- `clk_i` in 1: clock; all logic on the rising edge.
- `nreset_i` in 1: asynchronous, active-low reset.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: high only in IDLE; a command is accepted when `cmd_valid_i & cmd_ready_o`.
- `cmd_write_i` in 1: 1 = register write, 0 = read.
- `cmd_addr_i` in 16: register address.
- `cmd_value_i` in 32: write value.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_data_o` out 32: reply value, little-endian assembled; held until the next acceptance.
- `rsp_err_o` out 1: reply magic was not 0xAB; valid with `rsp_valid_o`.
- `rsp_timeout_o` out 1: transaction aborted by timeout; valid with `rsp_valid_o`.
- `nrxf_o` out 1: low = byte available to the core.
- `ntxe_o` out 1: low = the core may write.
- `nrd_i` in 1: core read strobe, active low.
- `wr_i` in 1: core write strobe; the byte is taken on its falling edge.
- `d_o` out 8: byte presented to the core.
- `d_oe_o` out 1: `d_o` drive enable, equal to `~nrd_i` while in SEND.
- `d_i` in 8: byte from the core.

## Operation
- Command frame, in order: 0xAA, `{7'b0, write}`, addr[7:0], addr[15:8], value[7:0], value[15:8], value[23:16], value[31:24]. Command fields are latched at acceptance.
- Reply frame: 0xAB, then data[7:0], data[15:8], data[23:16], data[31:24].
- States:
  - IDLE → SEND on acceptance. Byte index and timer clear; `rsp_*` flags clear.
  - SEND: `nrxf_o` low, `d_o` = frame[idx]. A read edge is `nrd_i` sampled 0 last cycle and 1 now. On a read edge, go to GAP.
  - GAP: `nrxf_o` high for exactly 1 cycle, then idx+1. Return to SEND if idx < 7; otherwise enter RECV with idx = 0.
  - RECV: `ntxe_o` low. A write edge is `wr_i` sampled 1 last cycle and 0 now. On each write edge, capture `d_i`. Byte 0 is compared with 0xAB and mismatch sets the error flag; bytes 1–4 go to `rsp_data_o[8k-1 -: 8]`. After byte 4, go to DONE.
  - DONE: `rsp_valid_o` = 1 for one cycle, then IDLE.
- Timeout: the counter clears on every read or write edge and increments otherwise in SEND, GAP, and RECV. When it reaches `TIMEOUT_CYCLES` it moves to DONE with `rsp_timeout_o` = 1 and `rsp_data_o` = 0.
- A bad magic does not abort; all 4 data bytes are still collected.
- Write edges outside RECV and read edges outside SEND are ignored.

## Timing
- Reset values: `cmd_ready_o` 1, `nrxf_o` 1, `ntxe_o` 1, `d_o` 0x00, `rsp_valid_o` 0, `rsp_data_o` 0, `rsp_err_o` 0, `rsp_timeout_o` 0, state IDLE.
- `nrxf_o` falls on the cycle after acceptance.
- A read edge detected in cycle N gives `nrxf_o` high in N+1 and low with the next byte in N+2.
- The last command byte's read edge (cycle N) gives `ntxe_o` low at N+2.
- The 5th write edge (cycle M) gives `rsp_valid_o` at M+1 and `cmd_ready_o` at M+2.
- Strobes are same-domain: one sampling register each, no synchronizer.
- Simultaneous `cmd_valid_i` during DONE is not accepted until IDLE.
- Reset asserted mid-transaction returns all outputs to reset values immediately; no partial response is emitted.

## Structure
- Package `ft_proto_pkg` holds:
  - `CMD_MAGIC` = 8'hAA and `REPLY_MAGIC` = 8'hAB;
  - `CMD_LEN` = 8 and `RSP_LEN` = 5;
  - the state enum (IDLE, SEND, GAP, RECV, DONE).
- One sub-module, `ft_strobe_edge`: a registered rise/fall detector, instanced for `nrd_i` and `wr_i`.

## Test plan
- Write 0x0001 ← 0xDEADBEEF against `host_iface` + `register` ADDR=1: bytes read are AA 01 01 00 EF BE AD DE. Reply is AB EF BE AD DE. `rsp_data_o` = 0xDEADBEEF, err 0, timeout 0.
- Read 0x0001 after writing 0x0000FFFF: frame byte 1 = 00; `rsp_data_o` = 0x0000FFFF.
- Responder stub replies 0x5A, 11, 22, 33, 44: `rsp_err_o` = 1, `rsp_data_o` = 0x44332211, exactly one `rsp_valid_o` pulse.
- Stub never pulses `nrd_i`, `TIMEOUT_CYCLES` = 16: `rsp_valid_o` with `rsp_timeout_o` = 1 at 16 cycles after `nrxf_o` falls; `nrxf_o` returns high.
- Deassert `nreset_i` after 3 command bytes: `nrxf_o` = 1, `cmd_ready_o` = 1 asynchronously, no `rsp_valid_o`; the next command restarts at 0xAA.
- `wr_i` falling edges during SEND: ignored; the reply still decodes correctly.

Source files
------------

// File: rtl/ft_proto_pkg.sv
// Shared constants, state encoding and frame builder for the FT2232-style
// byte-FIFO register protocol.
package ft_proto_pkg;

   localparam logic [7:0] CMD_MAGIC   = 8'hAA;
   localparam logic [7:0] REPLY_MAGIC = 8'hAB;
   localparam int         CMD_LEN     = 8;
   localparam int         RSP_LEN     = 5;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      GAP,
      RECV,
      DONE
   } state_t;

   // Byte 0 of the command frame sits in bits [7:0], byte 7 in bits [63:56].
   function automatic logic [63:0] build_cmd_frame(input logic        write,
                                                   input logic [15:0] addr,
                                                   input logic [31:0] value);
      return {value, addr, 7'b0, write, CMD_MAGIC};
   endfunction

endpackage

// File: rtl/ft_strobe_edge.sv
// Registered edge detector for a same-domain FIFO strobe; one sampling
// register, polarity chosen by parameter.
module ft_strobe_edge #(
   parameter logic IDLE_LEVEL  = 1'b0,
   parameter logic DETECT_RISE = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic strobe,
   output logic detected
);

   logic prev;

   // NOTE: sequential state uses non-blocking assignment so every flop
   // samples the pre-edge value, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= IDLE_LEVEL;
      else        prev <= strobe;
   end

   assign detected = DETECT_RISE ? (~prev & strobe) : (prev & ~strobe);

endmodule

// File: rtl/host_cmd_master.sv
// Host-side initiator: sends one 8-byte command frame through the RX-FIFO
// handshake and collects the 5-byte reply through the TX-FIFO handshake.
module host_cmd_master
   import ft_proto_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        nreset_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_write_i,
   input  logic [15:0] cmd_addr_i,
   input  logic [31:0] cmd_value_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic        rsp_timeout_o,
   output logic        nrxf_o,
   output logic        ntxe_o,
   input  logic        nrd_i,
   input  logic        wr_i,
   output logic [7:0]  d_o,
   output logic        d_oe_o,
   input  logic [7:0]  d_i
);

   localparam int             TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state;
   logic [2:0]    idx;
   logic [TW-1:0] timer;
   logic [63:0]   frame;
   logic          nrd_rise;
   logic          wr_fall;
   logic          active;
   logic          expire;
   logic [2:0]    next_idx;
   logic [1:0]    data_sel;

   ft_strobe_edge #(.IDLE_LEVEL(1'b1), .DETECT_RISE(1'b1)) u_nrd_edge (
      .clk      (clk_i),
      .rst_n    (nreset_i),
      .strobe   (nrd_i),
      .detected (nrd_rise)
   );

   ft_strobe_edge #(.IDLE_LEVEL(1'b0), .DETECT_RISE(1'b0)) u_wr_edge (
      .clk      (clk_i),
      .rst_n    (nreset_i),
      .strobe   (wr_i),
      .detected (wr_fall)
   );

   assign active   = (state == SEND) || (state == GAP) || (state == RECV);
   // The counter would reach TIMEOUT_CYCLES on this edge, so abort now.
   assign expire   = active && !(nrd_rise || wr_fall) && (timer == TIMER_LAST);
   assign next_idx = idx + 3'd1;
   assign data_sel = 2'(idx - 3'd1);
   assign d_oe_o   = (state == SEND) && !nrd_i;

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state         <= IDLE;
         idx           <= '0;
         timer         <= '0;
         frame         <= '0;
         cmd_ready_o   <= 1'b1;
         nrxf_o        <= 1'b1;
         ntxe_o        <= 1'b1;
         d_o           <= '0;
         rsp_valid_o   <= 1'b0;
         rsp_data_o    <= '0;
         rsp_err_o     <= 1'b0;
         rsp_timeout_o <= 1'b0;
      end else begin
         rsp_valid_o <= 1'b0;
         if (active) timer <= (nrd_rise || wr_fall) ? '0 : timer + TW'(1);

         if (expire) begin
            state         <= DONE;
            nrxf_o        <= 1'b1;
            ntxe_o        <= 1'b1;
            rsp_valid_o   <= 1'b1;
            rsp_timeout_o <= 1'b1;
            rsp_data_o    <= '0;
         end else begin
            case (state)
               IDLE: if (cmd_valid_i && cmd_ready_o) begin
                  frame         <= build_cmd_frame(cmd_write_i, cmd_addr_i, cmd_value_i);
                  d_o           <= CMD_MAGIC;
                  idx           <= '0;
                  timer         <= '0;
                  cmd_ready_o   <= 1'b0;
                  nrxf_o        <= 1'b0;
                  rsp_data_o    <= '0;
                  rsp_err_o     <= 1'b0;
                  rsp_timeout_o <= 1'b0;
                  state         <= SEND;
               end
               SEND: if (nrd_rise) begin
                  nrxf_o <= 1'b1;
                  state  <= GAP;
               end
               GAP: if (idx == 3'(CMD_LEN - 1)) begin
                  idx    <= '0;
                  ntxe_o <= 1'b0;
                  state  <= RECV;
               end else begin
                  idx    <= next_idx;
                  d_o    <= frame[{next_idx, 3'b000} +: 8];
                  nrxf_o <= 1'b0;
                  state  <= SEND;
               end
               RECV: if (wr_fall) begin
                  if (idx == '0) rsp_err_o <= (d_i != REPLY_MAGIC);
                  else           rsp_data_o[{data_sel, 3'b000} +: 8] <= d_i;
                  if (idx == 3'(RSP_LEN - 1)) begin
                     ntxe_o      <= 1'b1;
                     rsp_valid_o <= 1'b1;
                     state       <= DONE;
                  end else begin
                     idx <= next_idx;
                  end
               end
               DONE: begin
                  cmd_ready_o <= 1'b1;
                  state       <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_host_cmd_master.sv
// Self-checking bench for host_cmd_master: plays the core side of the byte
// FIFO and compares frames and replies against a behavioural model.
module tb_host_cmd_master;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        nreset_i = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_write_i = 1'b0;
   logic [15:0] cmd_addr_i = '0;
   logic [31:0] cmd_value_i = '0;
   logic        rsp_valid_o;
   logic [31:0] rsp_data_o;
   logic        rsp_err_o;
   logic        rsp_timeout_o;
   logic        nrxf_o;
   logic        ntxe_o;
   logic        nrd_i = 1'b1;
   logic        wr_i = 1'b0;
   logic [7:0]  d_o;
   logic        d_oe_o;
   logic [7:0]  d_i = '0;

   int n_checks = 0;
   int n_fail = 0;
   int pulse_cnt = 0;

   host_cmd_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk_i         (clk),
      .nreset_i      (nreset_i),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_write_i   (cmd_write_i),
      .cmd_addr_i    (cmd_addr_i),
      .cmd_value_i   (cmd_value_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_data_o    (rsp_data_o),
      .rsp_err_o     (rsp_err_o),
      .rsp_timeout_o (rsp_timeout_o),
      .nrxf_o        (nrxf_o),
      .ntxe_o        (ntxe_o),
      .nrd_i         (nrd_i),
      .wr_i          (wr_i),
      .d_o           (d_o),
      .d_oe_o        (d_oe_o),
      .d_i           (d_i)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rsp_valid_o === 1'b1) pulse_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   typedef struct {
      logic        write;
      logic [15:0] addr;
      logic [31:0] value;
      logic [39:0] reply;      // reply byte k in bits [8k+7:8k]
      logic        noise;      // toggle wr_i while the command is being read
      logic [63:0] exp_frame;  // command byte k in bits [8k+7:8k]
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait expired after 40 cycles", name);
   endtask

   // Reference model: frame and reply meaning straight from the protocol rules.
   function automatic logic [7:0] model_cmd_byte(input logic write, input logic [15:0] addr,
                                                 input logic [31:0] value, input int k);
      if (k == 0) return 8'hAA;
      if (k == 1) return write ? 8'h01 : 8'h00;
      if (k < 4)  return addr[8*(k-2) +: 8];
      return value[8*(k-4) +: 8];
   endfunction

   function automatic logic [31:0] model_rsp_data(input logic [39:0] reply);
      logic [31:0] acc = '0;
      for (int k = 1; k < 5; k++) acc += 32'(reply[8*k +: 8]) << (8 * (k - 1));
      return acc;
   endfunction

   task automatic wait_low(input bit use_ntxe, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if ((use_ntxe ? ntxe_o : nrxf_o) === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) bound_fail(use_ntxe ? "ntxe_wait" : "nrxf_wait");
   endtask

   task automatic accept_cmd(input logic write, input logic [15:0] addr, input logic [31:0] value);
      @(negedge clk);
      check("cmd_ready_idle", cmd_ready_o, 1);
      cmd_valid_i = 1'b1;
      cmd_write_i = write;
      cmd_addr_i  = addr;
      cmd_value_i = value;
      @(negedge clk);
      cmd_valid_i = 1'b0;
      cmd_value_i = $urandom;
      check("nrxf_after_accept", nrxf_o, 0);
      check("cmd_ready_busy", cmd_ready_o, 0);
   endtask

   task automatic read_byte(input bit noise, input bit last, output logic [7:0] b, output bit ok);
      b = '0;
      wait_low(1'b0, ok);
      if (!ok) return;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      nrd_i = 1'b0;
      if (noise) wr_i = 1'b1;
      @(negedge clk);
      check("d_oe_during_read", d_oe_o, 1);
      b = d_o;
      nrd_i = 1'b1;
      wr_i  = 1'b0;
      @(negedge clk);
      check("nrxf_gap_high", nrxf_o, 1);
      @(negedge clk);
      if (last) check("ntxe_after_frame", ntxe_o, 0);
      else      check("nrxf_next_byte", nrxf_o, 0);
   endtask

   task automatic run_txn(input logic write, input logic [15:0] addr, input logic [31:0] value,
                          input logic [39:0] reply, input bit noise,
                          output logic [63:0] frame, output logic [31:0] data,
                          output logic err, output logic tmo, output bit ok);
      int cnt0;
      logic [7:0] b;
      frame = '0; data = '0; err = 1'b0; tmo = 1'b0;
      accept_cmd(write, addr, value);
      cnt0 = pulse_cnt;
      for (int i = 0; i < 8; i++) begin
         read_byte(noise, i == 7, b, ok);
         if (!ok) return;
         frame[8*i +: 8] = b;
      end
      for (int k = 0; k < 5; k++) begin
         wait_low(1'b1, ok);
         if (!ok) return;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         d_i  = reply[8*k +: 8];
         wr_i = 1'b1;
         @(negedge clk);
         wr_i = 1'b0;
         @(negedge clk);
         d_i = 8'($urandom);
         if (k == 4) begin
            check("rsp_valid_after_last_write", rsp_valid_o, 1);
            data = rsp_data_o;
            err  = rsp_err_o;
            tmo  = rsp_timeout_o;
         end
      end
      @(negedge clk);
      check("cmd_ready_after_done", cmd_ready_o, 1);
      check("rsp_valid_one_cycle", rsp_valid_o, 0);
      @(negedge clk);
      check("rsp_pulse_count", 64'(pulse_cnt - cnt0), 1);
   endtask

   initial begin
      logic [63:0] frame, exp_frame;
      logic [31:0] data;
      logic [39:0] reply;
      logic        err, tmo, early;
      logic [7:0]  b;
      bit          ok;
      int          cnt0;
      logic        w;
      logic [15:0] a;
      logic [31:0] v;

      vecs[0] = '{1'b1, 16'h0001, 32'hDEADBEEF, 40'hDEADBEEFAB, 1'b0,
                  64'hDEADBEEF_000101AA, 32'hDEADBEEF, 1'b0};
      vecs[1] = '{1'b0, 16'h0001, 32'h00000000, 40'h0000FFFFAB, 1'b0,
                  64'h00000000_000100AA, 32'h0000FFFF, 1'b0};
      vecs[2] = '{1'b1, 16'h1234, 32'h00000000, 40'h443322115A, 1'b0,
                  64'h00000000_123401AA, 32'h44332211, 1'b1};
      vecs[3] = '{1'b1, 16'hBEEF, 32'hCAFEF00D, 40'hCAFEF00DAB, 1'b1,
                  64'hCAFEF00D_BEEF01AA, 32'hCAFEF00D, 1'b0};

      // Reset values
      #12;
      check("rst_cmd_ready", cmd_ready_o, 1);
      check("rst_nrxf", nrxf_o, 1);
      check("rst_ntxe", ntxe_o, 1);
      check("rst_d_o", d_o, 0);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_rsp_data", rsp_data_o, 0);
      check("rst_rsp_err", rsp_err_o, 0);
      check("rst_rsp_timeout", rsp_timeout_o, 0);
      @(negedge clk);
      nreset_i = 1'b1;
      repeat (2) @(negedge clk);

      // Directed table
      for (int t = 0; t < 4; t++) begin
         run_txn(vecs[t].write, vecs[t].addr, vecs[t].value, vecs[t].reply, vecs[t].noise,
                 frame, data, err, tmo, ok);
         check($sformatf("vec%0d_frame", t), frame, vecs[t].exp_frame);
         check($sformatf("vec%0d_data", t), data, vecs[t].exp_data);
         check($sformatf("vec%0d_err", t), err, vecs[t].exp_err);
         check($sformatf("vec%0d_timeout", t), tmo, 0);
      end

      // Timeout: core never reads
      accept_cmd(1'b1, 16'h0042, 32'h01020304);
      cnt0  = pulse_cnt;
      early = 1'b0;
      for (int c = 0; c < TIMEOUT; c++) begin
         if (rsp_valid_o !== 1'b0) early = 1'b1;
         @(negedge clk);
      end
      check("tmo_no_early_valid", early, 0);
      check("tmo_valid_at_limit", rsp_valid_o, 1);
      check("tmo_flag", rsp_timeout_o, 1);
      check("tmo_data_zero", rsp_data_o, 0);
      check("tmo_nrxf_high", nrxf_o, 1);
      @(negedge clk);
      check("tmo_cmd_ready", cmd_ready_o, 1);
      check("tmo_pulse_count", 64'(pulse_cnt - cnt0), 1);

      // Reset in the middle of a command frame
      accept_cmd(1'b1, 16'h00A5, 32'h55AA55AA);
      cnt0 = pulse_cnt;
      for (int i = 0; i < 3; i++) read_byte(1'b0, 1'b0, b, ok);
      nreset_i = 1'b0;
      #1;
      check("midrst_nrxf", nrxf_o, 1);
      check("midrst_cmd_ready", cmd_ready_o, 1);
      check("midrst_ntxe", ntxe_o, 1);
      check("midrst_d_o", d_o, 0);
      @(negedge clk);
      nreset_i = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_no_response", 64'(pulse_cnt - cnt0), 0);
      run_txn(vecs[0].write, vecs[0].addr, vecs[0].value, vecs[0].reply, 1'b0,
              frame, data, err, tmo, ok);
      check("postrst_first_byte", frame[7:0], 8'hAA);
      check("postrst_frame", frame, vecs[0].exp_frame);
      check("postrst_data", data, vecs[0].exp_data);

      // Randomised transactions against the model
      for (int t = 0; t < 20; t++) begin
         w = 1'($urandom);
         a = 16'($urandom);
         v = $urandom;
         reply = {$urandom, 8'hAB};
         if ($urandom_range(0, 3) == 0) reply[7:0] = 8'($urandom);
         exp_frame = '0;
         for (int k = 0; k < 8; k++) exp_frame[8*k +: 8] = model_cmd_byte(w, a, v, k);
         run_txn(w, a, v, reply, 1'($urandom), frame, data, err, tmo, ok);
         check($sformatf("rnd%0d_frame", t), frame, exp_frame);
         check($sformatf("rnd%0d_data", t), data, model_rsp_data(reply));
         check($sformatf("rnd%0d_err", t), err, reply[7:0] != 8'hAB);
         check($sformatf("rnd%0d_timeout", t), tmo, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
